// File: rtl/register_scoreboard_if.sv
// register_scoreboard_if: issue/writeback/decode bundle plus scoreboard status outputs.
// The pipeline drives through master; the scoreboard consumes through slave.
interface register_scoreboard_if #(
    parameter int AW = 4
);
    logic              issue_valid;
    logic              WriteReg_EX;
    logic              WriteR0_EX;
    logic [AW-1:0]     RN1_EX;
    logic              wb_valid;
    logic              wb_reg;
    logic              wb_r0;
    logic [AW-1:0]     wb_rn;
    logic              dec_valid;
    logic [AW-1:0]     RN1;
    logic [AW-1:0]     RN2;
    logic              rn1_used;
    logic              rn2_used;
    logic              flush;
    logic              stall;
    logic [2**AW-1:0]  busy;
    logic              sb_ovf;
    logic              sb_unf;
    logic              deadlock;

    modport master (
        output issue_valid, WriteReg_EX, WriteR0_EX, RN1_EX,
        output wb_valid, wb_reg, wb_r0, wb_rn,
        output dec_valid, RN1, RN2, rn1_used, rn2_used, flush,
        input  stall, busy, sb_ovf, sb_unf, deadlock
    );

    modport slave (
        input  issue_valid, WriteReg_EX, WriteR0_EX, RN1_EX,
        input  wb_valid, wb_reg, wb_r0, wb_rn,
        input  dec_valid, RN1, RN2, rn1_used, rn2_used, flush,
        output stall, busy, sb_ovf, sb_unf, deadlock
    );
endinterface

// File: rtl/register_scoreboard.sv
// register_scoreboard: per-register pending-write counters between EX and WB; stalls decode on owed operands.
// Optional SCOREBOARD_BYPASS_EN: an operand whose last pending write retires this cycle does not stall.
module register_scoreboard #(
    parameter int AW        = 4,
    parameter int CW        = 2,
    parameter int STALL_MAX = 15
) (
    input logic                 clk,
    input logic                 rst_n,
    register_scoreboard_if.slave sb
);
    localparam int NREG = 2**AW;
    localparam int SW   = $clog2(STALL_MAX + 1);
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic {RUN, STALL} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic [NREG-1:0] busy_q, busy_d, iss, wbs, blk;
    logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
    logic            ovf_q, ovf_d, unf_q, unf_d, deadlock_q, deadlock_d;
    logic            hazard;

    always_comb begin
        iss = '0;
        wbs = '0;
        iss[sb.RN1_EX] = sb.issue_valid & sb.WriteReg_EX;
        iss[0]         = iss[0] | (sb.issue_valid & sb.WriteR0_EX);
        wbs[sb.wb_rn]  = sb.wb_valid & sb.wb_reg;
        wbs[0]         = wbs[0] | (sb.wb_valid & sb.wb_r0);
        ovf_d = ovf_q;
        unf_d = unf_q;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = sb.flush ? '0 :
                       (iss[r] & ~wbs[r]) ? ((cnt_q[r] == CMAX) ? cnt_q[r] : cnt_q[r] + CW'(1)) :
                       (wbs[r] & ~iss[r]) ? ((cnt_q[r] == '0) ? cnt_q[r] : cnt_q[r] - CW'(1)) :
                       cnt_q[r];
            ovf_d = ovf_d | (~sb.flush & iss[r] & ~wbs[r] & (cnt_q[r] == CMAX));
            unf_d = unf_d | (~sb.flush & wbs[r] & ~iss[r] & (cnt_q[r] == '0));
            busy_d[r] = cnt_d[r] != '0;
`ifdef SCOREBOARD_BYPASS_EN
            blk[r] = busy_q[r] & ~(wbs[r] & (cnt_q[r] == CW'(1)));
`else
            blk[r] = busy_q[r];
`endif
        end
        hazard = sb.dec_valid & ((sb.rn1_used & blk[sb.RN1]) | (sb.rn2_used & blk[sb.RN2]));
        // Flush only releases an ongoing stall; a fresh hazard still enters STALL.
        state_d = (state_q == RUN) ? (hazard ? STALL : RUN) : ((hazard & ~sb.flush) ? STALL : RUN);
        stall_cnt_d = (state_d == STALL) ?
                      ((stall_cnt_q == SW'(STALL_MAX)) ? stall_cnt_q : stall_cnt_q + SW'(1)) : '0;
        deadlock_d = deadlock_q | (stall_cnt_d == SW'(STALL_MAX));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '{default: '0};
            busy_q      <= '0;
            state_q     <= RUN;
            stall_cnt_q <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            deadlock_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            deadlock_q  <= deadlock_d;
        end
    end

    assign sb.stall    = hazard;
    assign sb.busy     = busy_q;
    assign sb.sb_ovf   = ovf_q;
    assign sb.sb_unf   = unf_q;
    assign sb.deadlock = deadlock_q;
endmodule
